// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8N1, LSB first.
// Synchronises the raw line, validates the start bit at half a bit period,
// samples each data bit at mid-bit and checks the stop bit.
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   rxd        - raw serial line (asynchronous, idle high)
//   rxdata     - last correctly received byte, held until the next good frame
//   valid      - one-cycle pulse, rxdata updated this cycle
//   frame_err  - one-cycle pulse, stop bit sampled low
//   busy       - high whenever the receiver is not idle
module uart_rx #(
    parameter int unsigned BIT_CLK = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rxdata,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned HALF    = BIT_CLK / 2;
    localparam logic [7:0]  HALF_M1 = 8'(HALF - 1);
    localparam logic [7:0]  BIT_M1  = 8'(BIT_CLK - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic       s1;
    logic       rxd_s;
    logic [2:0] state,  state_n;
    logic [7:0] count,  count_n;
    logic [2:0] index,  index_n;
    logic [7:0] shreg,  shreg_n;
    logic [7:0] rxdata_n;
    logic       valid_n;
    logic       frame_err_n;
    logic       busy_n;

    // Two-flop synchroniser; resets high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            s1    <= rxd;
            rxd_s <= s1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            count     <= 8'd0;
            index     <= 3'd0;
            shreg     <= 8'd0;
            rxdata    <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            index     <= index_n;
            shreg     <= shreg_n;
            rxdata    <= rxdata_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            busy      <= busy_n;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n     = state;
        count_n     = count;
        index_n     = index;
        shreg_n     = shreg;
        rxdata_n    = rxdata;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_n = S_START;
                    count_n = 8'd0;
                end
            end
            S_START: begin
                count_n = count + 8'd1;
                if (count == HALF_M1) begin
                    // Still low at mid start bit: genuine start, else a glitch.
                    if (!rxd_s) begin
                        state_n = S_DATA;
                        count_n = 8'd0;
                        index_n = 3'd0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                count_n = count + 8'd1;
                if (count == BIT_M1) begin
                    shreg_n = {rxd_s, shreg[7:1]};
                    count_n = 8'd0;
                    index_n = index + 3'd1;
                    if (index == 3'd7) begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                count_n = count + 8'd1;
                if (count == BIT_M1) begin
                    count_n = 8'd0;
                    if (rxd_s) begin
                        rxdata_n = shreg;
                        valid_n  = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a break cannot retrigger.
                if (rxd_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: a line driver pushes the expected event
// (byte or framing error, with its arrival cycle) for every frame it sends;
// a monitor pops and compares whenever valid or frame_err pulses.
module tb_uart_rx;

    localparam int unsigned B    = 87;
    localparam int unsigned HALF = B / 2;
    localparam int          LAT  = 3 + HALF + 9 * B;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] rxdata;
    logic       valid;
    logic       frame_err;
    logic       busy;

    exp_t       q[$];
    int         cyc;
    int         n_cmp;
    int         n_err;
    logic [7:0] model_last;

    uart_rx #(.BIT_CLK(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rxdata    (rxdata),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame starting now; stop_bit selects good stop or framing error.
    // The line is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit);
        exp_t e;
        e.is_err = !stop_bit;
        e.data   = b;
        e.cyc    = cyc + LAT;
        q.push_back(e);
        rxd = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(B);
        end
        rxd = stop_bit;
        tick(B);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (valid || frame_err) begin
            chk("exclusive", !(valid && frame_err), int'({valid, frame_err}), 0);
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b rxdata=0x%0h, expected no pulse at cycle %0d",
                         valid, frame_err, rxdata, cyc);
            end else begin
                e = q.pop_front();
                chk("kind", frame_err == e.is_err, int'(frame_err), int'(e.is_err));
                chk("arrival_cycle", cyc == e.cyc, cyc, e.cyc);
                if (!e.is_err) begin
                    chk("rxdata", rxdata == e.data, int'(rxdata), int'(e.data));
                    model_last = e.data;
                end else begin
                    chk("rxdata_held", rxdata == model_last, int'(rxdata), int'(model_last));
                end
            end
        end
    end

    initial begin
        int         c;
        int         h;
        logic [7:0] b;
        bit         stop_ok;

        n_cmp      = 0;
        n_err      = 0;
        model_last = 8'h00;
        rxd        = 1'b1;
        reset      = 1'b0;
        tick(4);
        chk("reset_valid", valid == 1'b0, int'(valid), 0);
        chk("reset_busy", busy == 1'b0, int'(busy), 0);
        chk("reset_rxdata", rxdata == 8'h00, int'(rxdata), 0);
        reset = 1'b1;
        tick(1);

        // Idle line.
        tick(2000);
        chk("idle_busy", busy == 1'b0, int'(busy), 0);
        chk("idle_rxdata", rxdata == 8'h00, int'(rxdata), 0);

        // Single frame, then back-to-back frames.
        send_frame(8'hA5, 1'b1);
        tick(20);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(20);

        // Start glitch: 10 cycles low.
        c   = cyc;
        rxd = 1'b0;
        tick(5);
        chk("glitch_busy_high", busy == 1'b1, int'(busy), 1);
        tick(5);
        rxd = 1'b1;
        tick(c + 3 + HALF + 1 - cyc);
        chk("glitch_busy_low", busy == 1'b0, int'(busy), 0);
        tick(B);

        // Framing error with line held low afterwards.
        send_frame(8'h55, 1'b0);
        tick(300);
        rxd = 1'b1;
        h   = cyc;
        tick(1);
        chk("break_busy_high", busy == 1'b1, int'(busy), 1);
        tick(3);
        chk("break_busy_low", busy == 1'b0, int'(busy), 0);
        chk("break_rxdata", rxdata == 8'h3C, int'(rxdata), 8'h3C);
        send_frame(8'h12, 1'b1);
        tick(20);

        // Reset during data bit 4; the aborted frame produces nothing.
        b   = 8'h96;
        rxd = 1'b0;
        tick(B);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            tick(B);
        end
        rxd = b[4];
        tick(B / 2);
        reset = 1'b0;
        #1;
        chk("midreset_busy", busy == 1'b0, int'(busy), 0);
        chk("midreset_rxdata", rxdata == 8'h00, int'(rxdata), 0);
        chk("midreset_valid", valid == 1'b0, int'(valid), 0);
        model_last = 8'h00;
        rxd = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(5);
        send_frame(8'hC3, 1'b1);
        tick(10);

        // Randomised frames with occasional framing errors and random gaps.
        for (int k = 0; k < 12; k++) begin
            b       = 8'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
            send_frame(b, stop_ok);
            if (!stop_ok) begin
                tick($urandom_range(1, 40));
                rxd = 1'b1;
                tick($urandom_range(5, 30));
            end else begin
                tick($urandom_range(0, 30));
            end
        end

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 4000 && q.size() != 0; w++) begin
            tick(1);
        end
        chk("scoreboard_empty", q.size() == 0, q.size(), 0);
        tick(2 * B);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit, LSB first. The counterpart of the transmit stage. It takes the raw line from the pin, synchronises it, finds the start bit, samples each bit at mid-bit and delivers each byte as a one-cycle `valid` strobe with `rxdata`. Bad frames raise `frame_err` instead. Bit timing uses the same `BIT_CLK` clocks-per-bit convention as the transmitter, so a `uart_tx` and `uart_rx` pair with equal `BIT_CLK` interoperate.

## Interface
- `BIT_CLK`, default 87: clock cycles per bit. Legal range 4..256. `HALF = BIT_CLK/2` (integer division).
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `rxd`  in  1  raw serial line, asynchronous to `clk`, idle high.
- `rxdata`  out  8  last correctly received byte; holds until the next good frame.
- `valid`  out  1  one-cycle pulse, `rxdata` new this cycle.
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Synchroniser: two flops, `rxd` to `s1` to `rxd_s`. Both reset to 1 so that reset never fakes a start bit. All decisions use `rxd_s` only.
- Counter `count`: 8 bits, wide enough for 256. Bit index `index`: 3 bits. Shift register `shreg`: 8 bits.
- IDLE:
  - If `rxd_s == 0`, go to START with `count <= 0`.
- START (start-bit validation):
  - Increment `count`.
  - At `count == HALF-1`: if `rxd_s == 0`, go to DATA with `count <= 0`, `index <= 0`.
  - Otherwise it is a glitch: return to IDLE with no output.
- DATA:
  - Increment `count`.
  - At `count == BIT_CLK-1`: `shreg <= {rxd_s, shreg[7:1]}` (LSB first), `count <= 0`, `index <= index+1`.
  - When this happens with `index == 7`, go to STOP.
- STOP:
  - Increment `count`.
  - At `count == BIT_CLK-1`, if `rxd_s == 1`: `rxdata <= shreg`, pulse `valid`, go to IDLE.
  - If `rxd_s == 0`: pulse `frame_err`, leave `rxdata` unchanged, go to BREAK.
- BREAK:
  - Wait until `rxd_s == 1`, then go to IDLE.
  - This stops a held-low line (break) from retriggering.
- Undefined state encodings go to IDLE next cycle.
- There is no backpressure. The consumer must take `rxdata` on `valid`. `rxdata` stays stable until the next `valid`, which gives at least `HALF + 9*BIT_CLK` cycles to read it.

## Timing
- Reset values while `reset == 0`:
  - State IDLE, `count` 0, `index` 0, `shreg` 0, sync flops 1.
  - Outputs: `rxdata` 8'h00, `valid` 0, `frame_err` 0, `busy` 0.
- Reset mid-frame: the frame is abandoned immediately with no `valid` or `frame_err`. After release, the receiver waits in IDLE for the next low `rxd_s`.
- Input latency: `rxd` to `rxd_s` takes 2 cycles.
- Let E0 be the edge at which IDLE sees `rxd_s == 0`. Relative to E0:
  - Start validated at E(HALF).
  - Data bit i sampled at E(HALF + (i+1)*BIT_CLK).
  - Stop bit sampled at E(HALF + 9*BIT_CLK); `valid` or `frame_err` is high for exactly the one cycle after that edge.
- `busy` rises at E0 and falls on the same edge that raises `valid`, or when BREAK exits.
- Back-to-back frames: a start bit that begins right after the stop-bit sample is accepted. IDLE lasts 1 cycle minimum; no extra gap is required beyond the transmitter's own.
- `valid` and `frame_err` are never high together.

## Test plan
- Reset then idle line (`rxd = 1`, 2000 cycles) -> `valid`, `frame_err` and `busy` stay 0; `rxdata == 8'h00`.
- Single frame 8'hA5 from `uart_tx` (`BIT_CLK = 87`) -> exactly one `valid` pulse, `rxdata == 8'hA5`, arriving `HALF + 9*87` cycles after IDLE sees start; `frame_err` 0.
- Back-to-back 8'h00, 8'hFF, 8'h3C -> three `valid` pulses with those values in order; no frame errors.
- Start glitch: `rxd` low for 10 cycles then high (`BIT_CLK = 87`) -> receiver returns to IDLE, no output, `busy` drops by cycle HALF+1.
- Framing error: byte 8'h55 with stop bit driven 0, line held low 300 more cycles, then high -> one `frame_err` pulse, `rxdata` keeps its previous value, `busy` high until line high plus 2 cycles. The next good frame 8'h12 is received correctly.
- Reset asserted during data bit 4 of a frame -> outputs go to reset values at once. After release, the next full frame 8'hC3 gives `rxdata == 8'hC3` with no spurious pulse.
